// File: rtl/fft_rx_pkg.sv
// Shared types and field layout for the FFT result receiver.
package fft_rx_pkg;

  localparam int unsigned TDATA_W     = 32;
  localparam int unsigned TUSER_IN_W  = 24;
  localparam int unsigned TUSER_OUT_W = 16;
  localparam int unsigned RE_LSB      = 0;
  localparam int unsigned IM_LSB      = 16;
  localparam int unsigned EXP_LSB     = 16;
  localparam int unsigned BLK_EXP_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [TDATA_W-1:0]     tdata;
    logic                   tlast;
    logic [TUSER_OUT_W-1:0] tuser;
  } rx_word_t;

endpackage

// File: rtl/fft_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; count_o lets the writer reserve slots.
module fft_rx_fifo
  import fft_rx_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  rx_word_t         din_i,
  input  logic             pop_i,
  output rx_word_t         dout_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  rx_word_t         mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop_c, do_push_c;

  assign do_pop_c  = pop_i && (count_q != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push_c = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_c);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fft_result_rx.sv
// Frame checker and two-stage formatter for FFT output beats feeding an FWFT FIFO.
// Define FFT_RX_POWER_EN to emit re*re+im*im instead of the raw input word.
module fft_result_rx
  import fft_rx_pkg::*;
#(
  parameter int unsigned LOG2_LEN   = 13,
  parameter int unsigned IN_W       = 11,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                   i_aclk,
  input  logic                   i_rst,
  input  logic                   i_axi4s_data_tvalid,
  input  logic [TDATA_W-1:0]     i_axi4s_data_tdata,
  input  logic                   i_axi4s_data_tlast,
  input  logic [TUSER_IN_W-1:0]  i_axi4s_data_tuser,
  output logic                   o_axi4s_data_tvalid,
  input  logic                   i_axi4s_data_tready,
  output logic [TDATA_W-1:0]     o_axi4s_data_tdata,
  output logic                   o_axi4s_data_tlast,
  output logic [TUSER_OUT_W-1:0] o_axi4s_data_tuser,
  output logic [BLK_EXP_W-1:0]   o_blk_exp,
  output logic                   o_frame_done,
  output logic [15:0]            o_frame_cnt,
  input  logic                   i_err_clr,
  output logic                   o_err_seq,
  output logic                   o_err_ovf
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  rx_state_e            state_q, state_d;
  logic [LOG2_LEN-1:0]  exp_idx_q, exp_idx_d;
  logic [BLK_EXP_W-1:0] blk_exp_q, blk_exp_d;
  logic                 err_seq_q, err_ovf_q;
  logic                 frame_done_q;
  logic [15:0]          frame_cnt_q;

  logic                 wr_c, done_c, seq_err_c, ovf_err_c;
  logic [LOG2_LEN-1:0]  idx_c;
  logic [BLK_EXP_W-1:0] exp_c;
  logic                 idx_last_c, room_c;
  logic [OCC_W-1:0]     occ_c;

  logic                   s1_vld_q, s1_last_q, s1_done_q;
  logic [TUSER_OUT_W-1:0] s1_idx_q;
  logic                   s2_vld_q, s2_done_q;
  rx_word_t               s1_word_c, s2_word_q;

  rx_word_t         fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_c;

  assign idx_c      = i_axi4s_data_tuser[LOG2_LEN-1:0];
  assign exp_c      = i_axi4s_data_tuser[EXP_LSB +: BLK_EXP_W];
  assign idx_last_c = (idx_c == {LOG2_LEN{1'b1}});

  // Words already in flight hold a reserved slot, so the FIFO can never overflow.
  assign occ_c  = OCC_W'(fifo_count) + OCC_W'(s1_vld_q) + OCC_W'(s2_vld_q);
  assign room_c = (occ_c < OCC_W'(FIFO_DEPTH));

  // Frame sequencing: decide per accepted beat whether it is written or discarded.
  always_comb begin
    state_d   = state_q;
    exp_idx_d = exp_idx_q;
    blk_exp_d = blk_exp_q;
    wr_c      = 1'b0;
    done_c    = 1'b0;
    seq_err_c = 1'b0;
    ovf_err_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_axi4s_data_tvalid) begin
          if ((idx_c != '0) || i_axi4s_data_tlast) begin
            seq_err_c = 1'b1;
          end else if (!room_c) begin
            ovf_err_c = 1'b1;
            state_d   = ST_DROP;
          end else begin
            wr_c      = 1'b1;
            state_d   = ST_FRAME;
            exp_idx_d = LOG2_LEN'(1);
            blk_exp_d = exp_c;
          end
        end
      end
      ST_FRAME: begin
        if (i_axi4s_data_tvalid) begin
          if ((idx_c != exp_idx_q) || (i_axi4s_data_tlast != idx_last_c)) begin
            seq_err_c = 1'b1;
            state_d   = i_axi4s_data_tlast ? ST_IDLE : ST_DROP;
          end else if (!room_c) begin
            ovf_err_c = 1'b1;
            state_d   = i_axi4s_data_tlast ? ST_IDLE : ST_DROP;
          end else begin
            wr_c      = 1'b1;
            exp_idx_d = exp_idx_q + LOG2_LEN'(1);
            if (i_axi4s_data_tlast) begin
              done_c  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_DROP: begin
        if (i_axi4s_data_tvalid && i_axi4s_data_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      exp_idx_q <= '0;
      blk_exp_q <= '0;
      err_seq_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_idx_q <= exp_idx_d;
      blk_exp_q <= blk_exp_d;
      // A new error in the clearing cycle keeps its flag set.
      if (seq_err_c)      err_seq_q <= 1'b1;
      else if (i_err_clr) err_seq_q <= 1'b0;
      if (ovf_err_c)      err_ovf_q <= 1'b1;
      else if (i_err_clr) err_ovf_q <= 1'b0;
    end
  end

`ifdef FFT_RX_POWER_EN
  localparam int unsigned SQ_W  = 2 * IN_W;
  localparam int unsigned PWR_W = SQ_W + 1;

  logic signed [IN_W-1:0] re_c, im_c;
  logic signed [SQ_W-1:0] sq_re_c, sq_im_c;
  logic [SQ_W-1:0]        s1_sq_re_q, s1_sq_im_q;
  logic [PWR_W-1:0]       pwr_c;

  assign re_c    = i_axi4s_data_tdata[RE_LSB +: IN_W];
  assign im_c    = i_axi4s_data_tdata[IM_LSB +: IN_W];
  assign sq_re_c = re_c * re_c;
  assign sq_im_c = im_c * im_c;
  assign pwr_c   = PWR_W'(s1_sq_re_q) + PWR_W'(s1_sq_im_q);

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      s1_sq_re_q <= '0;
      s1_sq_im_q <= '0;
    end else begin
      s1_sq_re_q <= sq_re_c;
      s1_sq_im_q <= sq_im_c;
    end
  end

  assign s1_word_c.tdata = TDATA_W'(pwr_c);
  assign unused_c        = ^{i_axi4s_data_tuser, i_axi4s_data_tdata};
`else
  logic [TDATA_W-1:0] s1_data_q;

  always_ff @(posedge i_aclk) begin
    if (i_rst) s1_data_q <= '0;
    else       s1_data_q <= i_axi4s_data_tdata;
  end

  assign s1_word_c.tdata = s1_data_q;
  assign unused_c        = ^{i_axi4s_data_tuser, 1'(IN_W), 1'(RE_LSB), 1'(IM_LSB)};
`endif

  assign s1_word_c.tlast = s1_last_q;
  assign s1_word_c.tuser = s1_idx_q;

  // Two-stage pipeline; frame completion is reported on the FIFO write of the last word.
  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      s1_vld_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_done_q    <= 1'b0;
      s1_idx_q     <= '0;
      s2_vld_q     <= 1'b0;
      s2_done_q    <= 1'b0;
      s2_word_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      s1_vld_q     <= wr_c;
      s1_last_q    <= i_axi4s_data_tlast;
      s1_done_q    <= done_c;
      s1_idx_q     <= TUSER_OUT_W'(idx_c);
      s2_vld_q     <= s1_vld_q;
      s2_done_q    <= s1_vld_q & s1_done_q;
      s2_word_q    <= s1_word_c;
      frame_done_q <= s2_vld_q & s2_done_q;
      if (s2_vld_q && s2_done_q) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  fft_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_aclk),
    .rst_i   (i_rst),
    .push_i  (s2_vld_q),
    .din_i   (s2_word_q),
    .pop_i   (i_axi4s_data_tready),
    .dout_o  (fifo_dout),
    .valid_o (o_axi4s_data_tvalid),
    .count_o (fifo_count)
  );

  assign o_axi4s_data_tdata = fifo_dout.tdata;
  assign o_axi4s_data_tlast = fifo_dout.tlast;
  assign o_axi4s_data_tuser = fifo_dout.tuser;
  assign o_blk_exp          = blk_exp_q;
  assign o_frame_done       = frame_done_q;
  assign o_frame_cnt        = frame_cnt_q;
  assign o_err_seq          = err_seq_q;
  assign o_err_ovf          = err_ovf_q;

endmodule

// File: doc/fft_result_rx.md
FFT_RESULT_RX -- requirements
Module: fft_result_rx

Interface
REQ-001 Parameter LOG2_LEN, default 13, log2 of FFT frame length N (N=8192).
REQ-002 Parameter IN_W, default 11, signed width of each real/imag output component.
REQ-003 Parameter FIFO_DEPTH, default 16, output FIFO entries, power of two.
REQ-004 Port i_aclk, input, 1, single clock for all logic.
REQ-005 Port i_rst, input, 1, reset, synchronous, active-high.
REQ-006 Port i_axi4s_data_tvalid, input, 1, FFT output beat valid; no backpressure to the FFT exists.
REQ-007 Port i_axi4s_data_tdata, input, 32, re in [IN_W-1:0], im in [16+IN_W-1:16], sign-extended per 16-bit half.
REQ-008 Port i_axi4s_data_tlast, input, 1, last beat of frame.
REQ-009 Port i_axi4s_data_tuser, input, 24, bin index in [LOG2_LEN-1:0], block exponent in [20:16].
REQ-010 Port o_axi4s_data_tvalid / i_axi4s_data_tready, output/input, 1 each, downstream handshake.
REQ-011 Port o_axi4s_data_tdata, output, 32, result word (see REQ-030).
REQ-012 Port o_axi4s_data_tlast / o_axi4s_data_tuser, output, 1 / 16, frame end / zero-extended bin index.
REQ-013 Port o_blk_exp, output, 5, block exponent latched at index 0 of the current frame.
REQ-014 Port o_frame_done, output, 1, one-cycle pulse when a good frame's last beat enters the FIFO.
REQ-015 Port o_frame_cnt, output, 16, good-frame count, wraps 0xFFFF->0.
REQ-016 Port i_err_clr, input, 1, clears sticky errors; o_err_seq, o_err_ovf, outputs, 1 each, sticky.

Function
REQ-017 States IDLE, FRAME, DROP; a beat is accepted when i_axi4s_data_tvalid=1.
REQ-018 IDLE: index 0 beat -> FRAME, latch blk_exp, expected index=1; nonzero index -> discard, set o_err_seq.
REQ-019 FRAME: index==expected and tlast==(index==N-1) -> write beat, increment expected.
REQ-020 FRAME: index mismatch, early tlast, or missing tlast at N-1 -> discard beat, set o_err_seq, enter DROP, or IDLE if tlast=1.
REQ-021 DROP: discard all beats; tlast beat -> IDLE.
REQ-022 Good last beat (index N-1, tlast) -> IDLE, o_frame_done pulse, o_frame_cnt+1.
REQ-023 Beat arriving while FIFO has no free slot (including in-flight pipeline words) -> discard, set o_err_ovf, FRAME->DROP.
REQ-024 Partial frames already in the FIFO are not retracted; the consumer detects missing tlast via o_err_seq/o_err_ovf.
REQ-025 Accept-to-FIFO-write latency exactly 2 cycles; o_frame_done and o_frame_cnt update aligned with that write.
REQ-026 FIFO first-word-fall-through; pop when o_axi4s_data_tvalid and i_axi4s_data_tready; simultaneous push/pop on full FIFO is legal.
REQ-027 o_axi4s_data_tvalid never deasserts without a pop; data stable while stalled.
REQ-028 i_err_clr clears both sticky flags; an error in the same cycle wins (flag stays set).

Reset
REQ-029 i_rst: state IDLE, FIFO empty, o_axi4s_data_tvalid=0, o_frame_done=0, o_frame_cnt=0, o_blk_exp=0, o_err_seq=0, o_err_ovf=0, pipeline valids cleared; mid-frame reset discards the frame.

Configuration
REQ-030 Macro FFT_RX_POWER_EN defined: tdata = zero-extended re*re+im*im (2*IN_W+1 bits, unsigned), squared in stage 1, summed in stage 2; undefined: tdata = input word passed unchanged through the same 2 register stages.

Structure
REQ-031 Shared package fft_rx_pkg holds state enum, tdata/tuser field offsets, and blk_exp width.
REQ-032 Sub-module fft_rx_fifo: synchronous FWFT FIFO, count output for free-slot check.

Verification
REQ-033 Good frame, ready=1, re=3 im=-4 each beat, FFT_RX_POWER_EN -> 8192 words of 25, tlast on index 8191, o_frame_done once, o_frame_cnt=1.
REQ-034 Index jump 100->102 -> o_err_seq=1, no words after index 100 until next index 0 beat; next good frame counts.
REQ-035 ready=0 for 20 cycles during frame -> 16 words held, o_err_ovf=1, remainder dropped, tlast beat returns state to IDLE.
REQ-036 tlast at index 4000 -> o_err_seq=1, state IDLE, o_frame_cnt unchanged.
REQ-037 i_rst at index 5000, then full frame -> FIFO empty after reset, next frame passes, o_frame_cnt=1, o_blk_exp equals new frame value.
REQ-038 Macro undefined, tdata=0x07FF_0400 -> output 0x07FF_0400 two cycles after acceptance.
